// File: rtl/icache_pkg.sv
// Shared types, constants and address-field helpers for the direct-mapped I-cache.
package icache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          BYTE_BITS = 2;

    function automatic int woff_bits(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int idx_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_bits(input int addr_width, input int num_sets, input int words_per_line);
        return addr_width - BYTE_BITS - woff_bits(words_per_line) - idx_bits(num_sets);
    endfunction

    // Extract a bit field of 'width' bits starting at 'lsb'; caller narrows the result.
    function automatic logic [63:0] get_field(input logic [63:0] addr, input int lsb, input int width);
        return (addr >> lsb) & ((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Refill sequencer: latches the missing line, walks the beats, and tells the
// arrays when to write data, tag and valid.
module icache_refill_fsm
    import icache_pkg::*;
#(
    parameter  int ADDR_WIDTH     = 32,
    parameter  int WORDS_PER_LINE = 4,
    localparam int WOFF_W         = woff_bits(WORDS_PER_LINE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  mem_rvalid,
    output logic                  idle,
    output logic                  start,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [ADDR_WIDTH-1:0] line_base,
    output logic [WOFF_W-1:0]     beat_cnt,
    output logic                  data_we,
    output logic                  line_done,
    output logic                  line_valid,
    output logic                  clear_all
);

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~ADDR_WIDTH'((64'd1 << (WOFF_W + BYTE_BITS)) - 64'd1);
    localparam logic [WOFF_W-1:0] LAST_BEAT = WOFF_W'(WORDS_PER_LINE - 1);

    state_t state;
    logic   flush_pending;

    assign idle       = (state == IDLE);
    assign start      = idle && miss && !flush;
    assign data_we    = (state == REFILL) && mem_rvalid;
    assign line_done  = data_we && (beat_cnt == LAST_BEAT);
    assign line_valid = !flush_pending && !flush;
    // A flush seen during the refill only takes effect once the last beat lands.
    assign clear_all  = (idle && flush) || (line_done && !line_valid);
    assign mem_addr   = line_base + (ADDR_WIDTH'(beat_cnt) << BYTE_BITS);

    // Sequence IDLE -> REFILL -> IDLE, counting beats and tracking deferred flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            flush_pending <= 1'b0;
            line_base     <= '0;
            mem_req       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= REFILL;
                        line_base     <= pc & LINE_MASK;
                        beat_cnt      <= '0;
                        flush_pending <= 1'b0;
                        mem_req       <= 1'b1;
                    end
                end
                REFILL: begin
                    if (flush) flush_pending <= 1'b1;
                    if (data_we) beat_cnt <= beat_cnt + WOFF_W'(1);
                    if (line_done) begin
                        state         <= IDLE;
                        flush_pending <= 1'b0;
                        mem_req       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: same-cycle hit path, whole-line
// refill on miss, single-cycle global invalidate, saturating hit/miss counters.
module icache_dm
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SETS       = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  cache_stall,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    localparam int WOFF_W  = woff_bits(WORDS_PER_LINE);
    localparam int IDX_W   = idx_bits(NUM_SETS);
    localparam int TAG_W   = tag_bits(ADDR_WIDTH, NUM_SETS, WORDS_PER_LINE);
    localparam int IDX_LSB = BYTE_BITS + WOFF_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;

    logic [NUM_SETS-1:0]   valid;
    logic [TAG_W-1:0]      tag_mem  [NUM_SETS];
    logic [DATA_WIDTH-1:0] data_mem [NUM_SETS*WORDS_PER_LINE];

    logic [WOFF_W-1:0]     pc_woff;
    logic [IDX_W-1:0]      pc_idx;
    logic [TAG_W-1:0]      pc_tag;
    logic [IDX_W-1:0]      wr_idx;
    logic [TAG_W-1:0]      wr_tag;
    logic [ADDR_WIDTH-1:0] line_base;
    logic [WOFF_W-1:0]     beat_cnt;
    logic idle, start, data_we, line_done, line_valid, clear_all;
    logic hit, miss;

    assign pc_woff = WOFF_W'(get_field(64'(pc), BYTE_BITS, WOFF_W));
    assign pc_idx  = IDX_W'(get_field(64'(pc), IDX_LSB, IDX_W));
    assign pc_tag  = TAG_W'(get_field(64'(pc), TAG_LSB, TAG_W));
    assign wr_idx  = IDX_W'(get_field(64'(line_base), IDX_LSB, IDX_W));
    assign wr_tag  = TAG_W'(get_field(64'(line_base), TAG_LSB, TAG_W));

    // Lookup is only trusted in IDLE; during a refill every fetch stalls.
    assign hit         = idle && fetch_en && valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    assign miss        = fetch_en && !hit;
    assign cache_stall = fetch_en && !hit;
    assign instr       = hit ? data_mem[{pc_idx, pc_woff}] : DATA_WIDTH'(NOP_INSTR);

    icache_refill_fsm #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_refill (
        .clk        (clk),
        .rst        (rst),
        .miss       (miss),
        .flush      (flush),
        .pc         (pc),
        .mem_rvalid (mem_rvalid),
        .idle       (idle),
        .start      (start),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .line_base  (line_base),
        .beat_cnt   (beat_cnt),
        .data_we    (data_we),
        .line_done  (line_done),
        .line_valid (line_valid),
        .clear_all  (clear_all)
    );

    // Refill beats and the line tag land in the arrays; arrays carry no reset.
    always_ff @(posedge clk) begin
        if (!rst && data_we) data_mem[{wr_idx, beat_cnt}] <= mem_rdata;
        if (!rst && line_done) tag_mem[wr_idx] <= wr_tag;
    end

    // Valid bits: global clear wins over validating the freshly refilled line.
    always_ff @(posedge clk) begin
        if (rst || clear_all) valid <= '0;
        else if (line_done && line_valid) valid[wr_idx] <= 1'b1;
    end

    // Saturating hit/miss statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && hit_count != {CNT_WIDTH{1'b1}}) hit_count <= hit_count + CNT_WIDTH'(1);
            if (start && miss_count != {CNT_WIDTH{1'b1}}) miss_count <= miss_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
module tb_icache_dm;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam longint      CMAX = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, fetch_en, flush, mem_rvalid;
    logic [31:0] pc, mem_rdata, instr, mem_addr, hit_count, miss_count;
    logic        cache_stall, mem_req;

    always #5 clk = ~clk;

    icache_dm dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .pc          (pc),
        .flush       (flush),
        .instr       (instr),
        .cache_stall (cache_stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: cache contents by set, plus one outstanding line fill.
    bit          mv [64];
    logic [31:0] mt [64];
    logic [31:0] md [64][4];
    bit          m_busy, m_fp;
    logic [31:0] m_base;
    int          m_beats;
    longint      m_hc, m_mc;

    int          wcnt;
    bit          force_rv;
    logic [31:0] force_data;

    typedef struct {
        logic [31:0] pc;
        logic        exp_stall;
        logic [31:0] exp_instr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_hit();
        int idx;
        idx = int'(pc[9:4]);
        return !m_busy && fetch_en && mv[idx] && (mt[idx] == (pc >> 10));
    endfunction

    task automatic clear_valid();
        foreach (mv[i]) mv[i] = 1'b0;
    endtask

    task automatic model_reset();
        clear_valid();
        m_busy = 0; m_fp = 0; m_beats = 0; m_hc = 0; m_mc = 0; m_base = '0;
    endtask

    task automatic model_update(input bit h);
        int bidx;
        if (rst) begin
            model_reset();
            return;
        end
        if (h && m_hc < CMAX) m_hc++;
        if (!m_busy) begin
            if (flush) clear_valid();
            else if (fetch_en && !h) begin
                m_busy  = 1;
                m_base  = pc & ~32'hF;
                m_beats = 0;
                m_fp    = 0;
                if (m_mc < CMAX) m_mc++;
            end
        end else begin
            bidx = int'(m_base[9:4]);
            if (mem_rvalid) begin
                md[bidx][m_beats] = (m_base + 32'(m_beats * 4)) ^ KEY;
                if (m_beats == 3) begin
                    mt[bidx] = m_base >> 10;
                    if (m_fp || flush) clear_valid();
                    else mv[bidx] = 1'b1;
                    m_busy = 0;
                    m_fp   = 0;
                end else begin
                    m_beats++;
                    if (flush) m_fp = 1;
                end
            end else if (flush) m_fp = 1;
        end
    endtask

    // Memory: two idle cycles, then one data beat, repeated while mem_req is high.
    task automatic drive_mem();
        if (force_rv) begin
            mem_rvalid = 1'b1;
            mem_rdata  = force_data;
        end else if (mem_req === 1'b1) begin
            if (wcnt == 2) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_addr ^ KEY;
                wcnt       = 0;
            end else begin
                mem_rvalid = 1'b0;
                wcnt++;
            end
        end else begin
            mem_rvalid = 1'b0;
            wcnt       = 0;
        end
    endtask

    task automatic check_outputs();
        bit h;
        int idx, wo;
        h   = m_hit();
        idx = int'(pc[9:4]);
        wo  = int'(pc[3:2]);
        check("instr", instr, h ? md[idx][wo] : NOP);
        check("cache_stall", {31'b0, cache_stall}, {31'b0, fetch_en && !h});
        check("mem_req", {31'b0, mem_req}, {31'b0, m_busy});
        if (m_busy) check("mem_addr", mem_addr, m_base + 32'(m_beats * 4));
        check("hit_count", hit_count, m_hc[31:0]);
        check("miss_count", miss_count, m_mc[31:0]);
    endtask

    task automatic tick();
        bit h;
        drive_mem();
        #1;
        check_outputs();
        h = m_hit();
        @(posedge clk);
        model_update(h);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until_idle(output int n);
        n = 0;
        for (int i = 0; i < 60 && m_busy; i++) begin
            tick();
            n++;
        end
        if (m_busy) check("refill_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_beats(input int b);
        for (int i = 0; i < 40 && m_busy && m_beats < b; i++) tick();
        check("beat_reached", {31'b0, m_busy && m_beats == b}, 32'd1);
    endtask

    task automatic fetch_miss_fill(input logic [31:0] a);
        int n;
        pc = a; fetch_en = 1; flush = 0;
        tick();
        run_until_idle(n);
    endtask

    vec_t vecs [4];
    int   n;

    initial begin
        vecs[0] = '{32'h104, 1'b0, 32'hA5A5_0104};
        vecs[1] = '{32'h108, 1'b0, 32'hA5A5_0108};
        vecs[2] = '{32'h10C, 1'b0, 32'hA5A5_010C};
        vecs[3] = '{32'h100, 1'b0, 32'hA5A5_0100};
        foreach (md[i, j]) md[i][j] = '0;
        foreach (mt[i]) mt[i] = '0;

        rst = 1; fetch_en = 0; flush = 0; pc = '0;
        mem_rvalid = 0; mem_rdata = '0; force_rv = 0; force_data = '0; wcnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();

        // Reset state with a fetch request pending.
        fetch_en = 1; pc = 32'h100;
        #1 check("rst_mem_addr", mem_addr, 32'h0);
        tick();
        rst = 0;

        // Cold miss on 0x100 and its fill latency.
        pc = 32'h100; fetch_en = 1;
        tick();
        check("cold_miss_count", miss_count, 32'd1);
        check("cold_first_addr", mem_addr, 32'h100);
        run_until_idle(n);
        check("cold_latency", 32'(n), 32'd12);
        #1 check("cold_hit_instr", instr, 32'hA5A5_0100);
        check("cold_hit_stall", {31'b0, cache_stall}, 32'd0);
        tick();
        check("cold_hit_count", hit_count, 32'd1);

        // Same-line hits from a vector table.
        for (int i = 0; i < 4; i++) begin
            pc = vecs[i].pc; fetch_en = 1; flush = 0;
            #1;
            check("vec_stall", {31'b0, cache_stall}, {31'b0, vecs[i].exp_stall});
            check("vec_instr", instr, vecs[i].exp_instr);
            tick();
        end
        check("vec_miss_count", miss_count, 32'd1);

        // Conflict eviction: 0x500 shares set 16 with 0x100.
        fetch_miss_fill(32'h500);
        pc = 32'h500; tick();
        fetch_miss_fill(32'h100);
        pc = 32'h100;
        #1 check("evict_instr", instr, 32'hA5A5_0100);
        tick();
        check("evict_miss_count", miss_count, 32'd3);

        // Flush in IDLE invalidates the line.
        fetch_en = 0; flush = 1; tick();
        flush = 0; fetch_en = 1; pc = 32'h100;
        #1 check("flush_idle_stall", {31'b0, cache_stall}, 32'd1);
        tick();
        check("flush_idle_refill_addr", mem_addr, 32'h100);
        run_until_idle(n);
        tick();

        // Flush at beat 2 of a refill: fill completes, line stays invalid.
        pc = 32'h200; tick();
        wait_beats(2);
        flush = 1; tick();
        flush = 0;
        run_until_idle(n);
        pc = 32'h200;
        #1 check("flush_mid_stall", {31'b0, cache_stall}, 32'd1);
        pc = 32'h100;
        #1 check("flush_mid_other_stall", {31'b0, cache_stall}, 32'd1);
        fetch_miss_fill(32'h200);
        tick();

        // Reset after beat 1 of a refill, then a stray beat.
        pc = 32'h300; tick();
        wait_beats(1);
        rst = 1; tick();
        rst = 0;
        check("rst_mid_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mid_hits", hit_count, 32'd0);
        check("rst_mid_misses", miss_count, 32'd0);
        force_rv = 1; force_data = 32'hDEAD_BEEF; fetch_en = 0; tick();
        force_rv = 0;
        fetch_en = 1; pc = 32'h100; tick();
        check("rst_restart_addr", mem_addr, 32'h100);
        run_until_idle(n);
        tick();

        // fetch_en low during a refill: no stall, fill still completes.
        pc = 32'h400; tick();
        fetch_en = 0;
        run_until_idle(n);
        fetch_en = 1; pc = 32'h404;
        #1 check("fe_low_hit_instr", instr, 32'hA5A5_0404);
        tick();

        // pc wanders during a refill; latched line base is used.
        pc = 32'h600; tick();
        pc = 32'h1234;
        run_until_idle(n);
        pc = 32'h600;
        #1 check("pc_change_instr", instr, 32'hA5A5_0600);
        tick();

        // Randomized traffic over a small set of conflicting lines.
        for (int i = 0; i < 2500; i++) begin
            pc       = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2);
            fetch_en = ($urandom_range(0, 9) < 8);
            flush    = ($urandom_range(0, 39) == 0);
            rst      = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0; flush = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
